// File: rtl/mem_access_unit.sv
// Memory-stage access unit: decodes loads/stores, checks address legality and
// runs a three-state handshake with the bus bridge while stalling the pipeline.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MemOp_MEMin,
    input  logic [31:0] ALUresult_MEMin,
    input  logic [31:0] RD2_MEMin,
    input  logic        expFlag_MEMin,
    input  logic [4:0]  ExcCode_MEMin,
    input  logic        clearAll,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    output logic        stall_MEM,
    output logic [31:0] MemData_MEMout,
    output logic        expFlag_MEMout,
    output logic [4:0]  ExcCode_MEMout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] OP_SW  = 4'd1;
    localparam logic [3:0] OP_SH  = 4'd2;
    localparam logic [3:0] OP_SB  = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LH  = 4'd5;
    localparam logic [3:0] OP_LHU = 4'd6;
    localparam logic [3:0] OP_LB  = 4'd7;
    localparam logic [3:0] OP_LBU = 4'd8;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    state_t      state;
    logic [3:0]  op_q;
    logic [1:0]  off_q;

    logic        op_valid;
    logic        is_store;
    logic        is_word;
    logic        is_half;
    logic        in_dm;
    logic        in_timer;
    logic        misaligned;
    logic        local_exc;
    logic        start;
    logic [3:0]  byteen_d;
    logic [31:0] wdata_d;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op_valid   = (MemOp_MEMin >= OP_SW) && (MemOp_MEMin <= OP_LBU);
        is_store   = (MemOp_MEMin == OP_SW) || (MemOp_MEMin == OP_SH) || (MemOp_MEMin == OP_SB);
        is_word    = (MemOp_MEMin == OP_SW) || (MemOp_MEMin == OP_LW);
        is_half    = (MemOp_MEMin == OP_SH) || (MemOp_MEMin == OP_LH) || (MemOp_MEMin == OP_LHU);
        in_dm      = ALUresult_MEMin < 32'h0000_3000;
        in_timer   = ((ALUresult_MEMin >= 32'h0000_7F00) && (ALUresult_MEMin <= 32'h0000_7F0B)) ||
                     ((ALUresult_MEMin >= 32'h0000_7F10) && (ALUresult_MEMin <= 32'h0000_7F1B));
        misaligned = (is_word && (ALUresult_MEMin[1:0] != 2'b00)) || (is_half && ALUresult_MEMin[0]);
        // Offset 8 of either timer is its read-only count register.
        local_exc  = op_valid && (misaligned || !(in_dm || in_timer) ||
                     (in_timer && !is_word) ||
                     (in_timer && is_store && (ALUresult_MEMin[3:0] == 4'h8)));
    end

    assign start = (state == IDLE) && op_valid && !expFlag_MEMin && !local_exc && !clearAll;

    // Accesses that start never carry an exception, so outside IDLE the
    // exception outputs stay at zero until the FSM is back in IDLE.
    always_comb begin
        expFlag_MEMout = 1'b0;
        ExcCode_MEMout = 5'd0;
        if ((state == IDLE) && reset) begin
            if (expFlag_MEMin) begin
                expFlag_MEMout = 1'b1;
                ExcCode_MEMout = ExcCode_MEMin;
            end else if (local_exc) begin
                expFlag_MEMout = 1'b1;
                ExcCode_MEMout = is_store ? EXC_ADES : EXC_ADEL;
            end
        end
    end

    assign stall_MEM = (start && reset) || (state == ACCESS);

    always_comb begin
        byteen_d = 4'b0000;
        wdata_d  = 32'd0;
        case (MemOp_MEMin)
            OP_SW: begin
                byteen_d = 4'b1111;
                wdata_d  = RD2_MEMin;
            end
            OP_SH: begin
                byteen_d = ALUresult_MEMin[1] ? 4'b1100 : 4'b0011;
                wdata_d  = {2{RD2_MEMin[15:0]}};
            end
            OP_SB: begin
                byteen_d = 4'b0001 << ALUresult_MEMin[1:0];
                wdata_d  = {4{RD2_MEMin[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b = bus_rdata[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_q)
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'd0, lane_h};
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'd0, lane_b};
            default: load_data = bus_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 32'd0;
            bus_byteen     <= 4'b0000;
            bus_wdata      <= 32'd0;
            MemData_MEMout <= 32'd0;
            op_q           <= 4'd0;
            off_q          <= 2'd0;
        end else if (clearAll) begin
            // A store whose ready coincides with the flush already reached the bridge.
            state          <= IDLE;
            bus_req        <= 1'b0;
            MemData_MEMout <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCESS;
                        bus_req    <= 1'b1;
                        bus_we     <= is_store;
                        bus_addr   <= {ALUresult_MEMin[31:2], 2'b00};
                        bus_byteen <= byteen_d;
                        bus_wdata  <= wdata_d;
                        op_q       <= MemOp_MEMin;
                        off_q      <= ALUresult_MEMin[1:0];
                    end
                end
                ACCESS: begin
                    if (bus_ready) begin
                        state          <= DONE;
                        bus_req        <= 1'b0;
                        MemData_MEMout <= load_data;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a bridge model answers requests and
// a scoreboard of expected bus transactions and load results is checked in order.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  MemOp_MEMin;
    logic [31:0] ALUresult_MEMin;
    logic [31:0] RD2_MEMin;
    logic        expFlag_MEMin;
    logic [4:0]  ExcCode_MEMin;
    logic        clearAll;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        stall_MEM;
    logic [31:0] MemData_MEMout;
    logic        expFlag_MEMout;
    logic [4:0]  ExcCode_MEMout;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks;
    int   n_fails;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .MemOp_MEMin     (MemOp_MEMin),
        .ALUresult_MEMin (ALUresult_MEMin),
        .RD2_MEMin       (RD2_MEMin),
        .expFlag_MEMin   (expFlag_MEMin),
        .ExcCode_MEMin   (ExcCode_MEMin),
        .clearAll        (clearAll),
        .bus_rdata       (bus_rdata),
        .bus_ready       (bus_ready),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_byteen      (bus_byteen),
        .bus_wdata       (bus_wdata),
        .stall_MEM       (stall_MEM),
        .MemData_MEMout  (MemData_MEMout),
        .expFlag_MEMout  (expFlag_MEMout),
        .ExcCode_MEMout  (ExcCode_MEMout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts at a falling edge; drives one access, plays the bridge with
    // bus_ready high in ACCESS cycle number `delay`, and returns at a falling edge.
    task automatic run_access(input string name, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int delay,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_data, input int exp_stall);
        txn_t        t;
        txn_t        cur;
        int          stalls;
        int          acc;
        bit          done;
        bit          stable;
        bit          is_st;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  b0;
        is_st   = (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
        t.addr  = {addr[31:2], 2'b00};
        t.we    = is_st;
        t.be    = exp_be;
        t.wdata = exp_wd;
        t.data  = exp_data;
        exp_q.push_back(t);
        cur = t;
        a0 = '0; w0 = '0; b0 = '0;
        MemOp_MEMin = op; ALUresult_MEMin = addr; RD2_MEMin = wd;
        bus_rdata = rd; bus_ready = 1'b0;
        stalls = 0; acc = 0; done = 1'b0; stable = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            #1;
            if (stall_MEM) stalls++;
            if (bus_req) begin
                acc++;
                if (acc == 1) begin
                    if (exp_q.size() == 0) check({name, " unexpected request"}, 32'd1, 32'd0);
                    else cur = exp_q.pop_front();
                    check({name, " addr"}, bus_addr, cur.addr);
                    check({name, " we"}, 32'(bus_we), 32'(cur.we));
                    if (cur.we) begin
                        check({name, " byteen"}, 32'(bus_byteen), 32'(cur.be));
                        check({name, " wdata"}, bus_wdata, cur.wdata);
                    end
                    a0 = bus_addr; b0 = bus_byteen; w0 = bus_wdata;
                end else if (bus_addr !== a0 || bus_byteen !== b0 || bus_wdata !== w0 ||
                             bus_we !== cur.we) begin
                    stable = 1'b0;
                end
                bus_ready = (acc == delay);
            end else if (acc > 0) begin
                check({name, " done stall"}, 32'(stall_MEM), 32'd0);
                if (!cur.we) check({name, " data"}, MemData_MEMout, cur.data);
                MemOp_MEMin = 4'd0;
                bus_ready = 1'b0;
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            check({name, " timeout"}, 32'd0, 32'd1);
            MemOp_MEMin = 4'd0;
            bus_ready = 1'b0;
        end
        check({name, " stall cycles"}, 32'(stalls), 32'(exp_stall));
        check({name, " bus stable"}, 32'(stable), 32'd1);
    endtask

    task automatic run_exc(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic ein, input logic [4:0] ecode,
                           input logic exp_flag, input logic [4:0] exp_code);
        bit req_seen;
        MemOp_MEMin = op; ALUresult_MEMin = addr; RD2_MEMin = 32'h1111_2222;
        expFlag_MEMin = ein; ExcCode_MEMin = ecode;
        req_seen = 1'b0;
        #1;
        check({name, " flag"}, 32'(expFlag_MEMout), 32'(exp_flag));
        check({name, " code"}, 32'(ExcCode_MEMout), 32'(exp_code));
        check({name, " stall"}, 32'(stall_MEM), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus_req) req_seen = 1'b1;
        end
        check({name, " no request"}, 32'(req_seen), 32'd0);
        check({name, " code held"}, 32'(ExcCode_MEMout), 32'(exp_code));
        @(negedge clk);
        MemOp_MEMin = 4'd0; expFlag_MEMin = 1'b0; ExcCode_MEMin = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b0; clearAll = 1'b0;
        MemOp_MEMin = 4'd4; ALUresult_MEMin = 32'h4; RD2_MEMin = '0;
        expFlag_MEMin = 1'b1; ExcCode_MEMin = 5'd10;
        bus_rdata = '0; bus_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset stall", 32'(stall_MEM), 32'd0);
        check("reset req", 32'(bus_req), 32'd0);
        check("reset expflag", 32'(expFlag_MEMout), 32'd0);
        check("reset exccode", 32'(ExcCode_MEMout), 32'd0);
        check("reset addr", bus_addr, 32'd0);
        check("reset memdata", MemData_MEMout, 32'd0);
        MemOp_MEMin = 4'd0; expFlag_MEMin = 1'b0; ExcCode_MEMin = 5'd0;
        reset = 1'b1;
        @(negedge clk);

        //         name     op     addr           wdata          rdata          dly be       wdata exp      data exp       stall
        run_access("lw",    4'd4, 32'h0000_0004, 32'h0,         32'h1234_5678, 1, 4'b0000, 32'h0,         32'h1234_5678, 2);
        run_access("lb",    4'd7, 32'h0000_0003, 32'h0,         32'h80FF_FFFF, 1, 4'b0000, 32'h0,         32'hFFFF_FF80, 2);
        run_access("lbu",   4'd8, 32'h0000_0003, 32'h0,         32'h80FF_FFFF, 1, 4'b0000, 32'h0,         32'h0000_0080, 2);
        run_access("lh",    4'd5, 32'h0000_0002, 32'h0,         32'h8001_1234, 2, 4'b0000, 32'h0,         32'hFFFF_8001, 3);
        run_access("lhu",   4'd6, 32'h0000_0006, 32'h0,         32'h8001_1234, 1, 4'b0000, 32'h0,         32'h0000_8001, 2);
        run_access("sh",    4'd2, 32'h0000_0102, 32'h0000_ABCD, 32'h0,         4, 4'b1100, 32'hABCD_ABCD, 32'h0,         5);
        run_access("sw",    4'd1, 32'h0000_2FFC, 32'hDEAD_BEEF, 32'h0,         1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         2);
        run_access("sb",    4'd3, 32'h0000_0001, 32'h0000_005A, 32'h0,         2, 4'b0010, 32'h5A5A_5A5A, 32'h0,         3);
        run_access("lw tmr",4'd4, 32'h0000_7F14, 32'h0,         32'h0000_0055, 1, 4'b0000, 32'h0,         32'h0000_0055, 2);
        run_access("sw tmr",4'd1, 32'h0000_7F10, 32'h0000_0009, 32'h0,         1, 4'b1111, 32'h0000_0009, 32'h0,         2);
        run_access("lbu2",  4'd8, 32'h0000_0003, 32'h0,         32'h80FF_FFFF, 1, 4'b0000, 32'h0,         32'h0000_0080, 2);

        run_exc("lw misalign", 4'd4, 32'h0000_0002, 1'b0, 5'd0,  1'b1, 5'd4);
        run_exc("sb timer",    4'd3, 32'h0000_7F00, 1'b0, 5'd0,  1'b1, 5'd5);
        run_exc("sw count",    4'd1, 32'h0000_7F08, 1'b0, 5'd0,  1'b1, 5'd5);
        run_exc("exc in",      4'd4, 32'h0000_0004, 1'b1, 5'd10, 1'b1, 5'd10);
        run_exc("lw range",    4'd4, 32'h0000_3000, 1'b0, 5'd0,  1'b1, 5'd4);
        run_exc("sh misalign", 4'd2, 32'h0000_0001, 1'b0, 5'd0,  1'b1, 5'd5);
        run_exc("op none",     4'd9, 32'h0000_0002, 1'b0, 5'd0,  1'b0, 5'd0);

        // bus_ready with no request outstanding must change nothing.
        bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("idle ready req", 32'(bus_req), 32'd0);
        check("idle ready data", MemData_MEMout, 32'h0000_0080);
        bus_ready = 1'b0;

        // Flush in the second ACCESS cycle of a load.
        MemOp_MEMin = 4'd4; ALUresult_MEMin = 32'h10; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        check("flush access1 req", 32'(bus_req), 32'd1);
        @(negedge clk);
        check("flush access2 stall", 32'(stall_MEM), 32'd1);
        clearAll = 1'b1; MemOp_MEMin = 4'd0;
        @(negedge clk);
        clearAll = 1'b0;
        #1;
        check("flush req", 32'(bus_req), 32'd0);
        check("flush stall", 32'(stall_MEM), 32'd0);
        check("flush memdata", MemData_MEMout, 32'd0);
        @(negedge clk);
        check("flush stays idle", 32'(bus_req), 32'd0);

        // Reset pulsed while the bridge is stalled.
        MemOp_MEMin = 4'd1; ALUresult_MEMin = 32'h20; RD2_MEMin = 32'hCAFE_0001;
        @(negedge clk);
        #1;
        check("rst pre req", 32'(bus_req), 32'd1);
        reset = 1'b0;
        #1;
        check("rst req", 32'(bus_req), 32'd0);
        check("rst stall", 32'(stall_MEM), 32'd0);
        check("rst we", 32'(bus_we), 32'd0);
        check("rst addr", bus_addr, 32'd0);
        check("rst byteen", 32'(bus_byteen), 32'd0);
        check("rst wdata", bus_wdata, 32'd0);
        check("rst expflag", 32'(expFlag_MEMout), 32'd0);
        @(negedge clk);
        MemOp_MEMin = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        run_access("post rst lw", 4'd4, 32'h0000_2FFC, 32'h0, 32'hCAFE_F00D, 1, 4'b0000, 32'h0, 32'hCAFE_F00D, 2);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL provide `reset`, input, 1 bit: asynchronous, active-low reset; low forces the reset state immediately, independent of `clk`.
REQ-003 SHALL provide `MemOp_MEMin`, input, 4 bits: the access code. 0 none, 1 sw, 2 sh, 3 sb, 4 lw, 5 lh, 6 lhu, 7 lb, 8 lbu; 9-15 are treated as none.
REQ-004 SHALL provide `ALUresult_MEMin`, input, 32 bits: the byte address of the access.
REQ-005 SHALL provide `RD2_MEMin`, input, 32 bits: the store data (already forwarded).
REQ-006 SHALL provide `expFlag_MEMin` (input, 1 bit) and `ExcCode_MEMin` (input, 5 bits): the exception carried from earlier stages.
REQ-007 SHALL provide `clearAll`, input, 1 bit: the pipeline flush from CP0.
REQ-008 SHALL provide `bus_rdata`, input, 32 bits: read data from the bridge.
REQ-009 SHALL provide `bus_ready`, input, 1 bit: the bridge has completed the current request this cycle.
REQ-010 SHALL provide `bus_req` (output, 1 bit) and `bus_we` (output, 1 bit): a request is active, and it is a write.
REQ-011 SHALL provide `bus_addr`, output, 32 bits: the word-aligned address, `ALUresult_MEMin` with bits [1:0] forced to 0.
REQ-012 SHALL provide `bus_byteen` (output, 4 bits) and `bus_wdata` (output, 32 bits): byte enables, and store data shifted into the lanes it occupies.
REQ-013 SHALL provide `stall_MEM`, output, 1 bit: freezes the EX/MEM register and every stage upstream of it.
REQ-014 SHALL provide `MemData_MEMout`, output, 32 bits: load data, extended, valid in DONE.
REQ-015 SHALL provide `expFlag_MEMout` (output, 1 bit) and `ExcCode_MEMout` (output, 5 bits): the exception passed on to CP0.

Function
REQ-016 SHALL decode legal regions as: DM 0x0000-0x2FFF; Timer0 0x7F00-0x7F0B; Timer1 0x7F10-0x7F1B.
REQ-017 SHALL raise AdEL (4) for a load, or AdES (5) for a store, on any of these conditions:
- misaligned word or halfword access;
- address outside all legal regions;
- non-word access to a timer;
- store to timer offset 8 (the count register).
REQ-018 SHALL, when `expFlag_MEMin`=1, pass `ExcCode_MEMin` through unchanged and perform no bus access; an incoming exception has priority over a local one.
REQ-019 SHALL compute the exception outputs combinationally in IDLE and hold them constant until leaving DONE.
REQ-020 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-021 SHALL, in IDLE, go to ACCESS when the code is valid (1-8) and there is no exception; otherwise stay in IDLE with `stall_MEM`=0.
REQ-022 SHALL register `bus_addr`, `bus_we`, `bus_byteen` and `bus_wdata` on the IDLE->ACCESS edge.
REQ-023 SHALL assert `stall_MEM`=1 in the IDLE cycle that starts an access and in every ACCESS cycle.
REQ-024 SHALL, in ACCESS, hold `bus_req`=1 and all bus outputs stable until `bus_ready`=1; on that edge capture `bus_rdata` and go to DONE.
REQ-025 SHALL wait in ACCESS with no timeout.
REQ-026 SHALL, in DONE, drive `stall_MEM`=0 and `bus_req`=0, present `MemData_MEMout`, and return to IDLE on the next edge.
REQ-027 SHALL give a minimum latency of 3 cycles (IDLE, ACCESS, DONE) when `bus_ready` is high in the first ACCESS cycle.
REQ-028 SHALL generate byte enables as follows:
- sw: 1111;
- sh: 0011 when addr[1]=0, 1100 when addr[1]=1;
- sb: 0001 shifted left by addr[1:0].
REQ-029 SHALL replicate store data into the enabled lanes.
REQ-030 SHALL extend load data as follows:
- lw: unchanged;
- lh/lb: select the lane by addr[1:0] and sign-extend;
- lhu/lbu: select the lane by addr[1:0] and zero-extend.
REQ-031 SHALL, on `clearAll`=1 in any state, go to IDLE on the next edge, drop `bus_req` and clear the captured data.
REQ-032 SHALL treat a store as committed if `bus_ready` coincides with `clearAll`.
REQ-033 SHALL ignore `bus_ready` whenever `bus_req`=0.

Reset
REQ-034 SHALL, while `reset`=0, hold: state IDLE; `bus_req`, `bus_we`, `stall_MEM` and `expFlag_MEMout` = 0; `bus_addr`, `bus_byteen`, `bus_wdata`, `MemData_MEMout` and `ExcCode_MEMout` = 0.
REQ-035 SHALL, when reset is asserted during ACCESS, drop `bus_req` asynchronously; after release the FSM starts in IDLE.

Verification
REQ-036 SHALL cover lw at 0x0004 with `bus_ready` high on the first ACCESS cycle and `bus_rdata`=0x12345678 -> `stall_MEM` high for 2 cycles, then DONE with `MemData_MEMout`=0x12345678.
REQ-037 SHALL cover lb at 0x0003 with `bus_rdata`=0x80FFFFFF -> `MemData_MEMout`=0xFFFFFF80; the same stimulus as lbu -> 0x00000080.
REQ-038 SHALL cover sh at 0x0102 with data 0x0000ABCD and `bus_ready` delayed 4 cycles -> `bus_byteen`=1100 and `bus_wdata`=0xABCDABCD held stable for 4 cycles; `stall_MEM` high for 5 cycles.
REQ-039 SHALL cover these exception cases, each with `bus_req` never asserted:
- lw at 0x0002 -> `expFlag_MEMout`=1, `ExcCode_MEMout`=4;
- sb at 0x7F00 -> ExcCode 5;
- sw at 0x7F08 -> ExcCode 5;
- `expFlag_MEMin`=1 with code 10 -> code 10 passed through.
REQ-040 SHALL cover `clearAll` asserted in the 2nd ACCESS cycle of a lw -> IDLE next cycle with `bus_req`=0 and `stall_MEM`=0; and `reset` pulsed low mid-ACCESS -> all outputs 0 immediately.
